// File: rtl/svsd_write_arbiter.sv
`default_nettype none
// ============================================================================
// svsd_write_arbiter : two-requester round-robin write sequencer for the
// seven-segment PIO output register (write, optional read-back verify, ack).
// Revision 1.0
// ============================================================================
module svsd_write_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter bit          VERIFY = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [1:0]        m_address,
   output logic              m_chipselect,
   output logic              m_write_n,
   output logic [DATA_W-1:0] m_writedata,
   input  logic [DATA_W-1:0] m_readdata,
   input  logic              err_clr,
   output logic              busy,
   output logic              verify_err,
   output logic              last_grant
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WRITE  = 2'd1,
      S_VERIFY = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              gnt_q, gnt_d;
   logic              last_grant_q, last_grant_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              cs_q, cs_d;
   logic              write_n_q, write_n_d;
   logic [DATA_W-1:0] writedata_q, writedata_d;
   logic              busy_q, busy_d;
   logic              verify_err_q, verify_err_d;
   logic              winner;

   // On a tie the requester not served last time wins.
   always_comb begin
      winner = 1'b0;
      if (req0 && req1) begin
         winner = ~last_grant_q;
      end else if (req1) begin
         winner = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               state_d = S_WRITE;
               gnt_d   = winner;
               hold_d  = winner ? wdata1 : wdata0;
            end
         end
         S_WRITE:  state_d = VERIFY ? S_VERIFY : S_DONE;
         S_VERIFY: state_d = S_DONE;
         S_DONE: begin
            state_d      = S_IDLE;
            last_grant_d = gnt_q;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // A mismatch in the same cycle as err_clr keeps the flag set.
   always_comb begin
      verify_err_d = verify_err_q;
      if ((state_q == S_VERIFY) && (m_readdata != hold_q)) begin
         verify_err_d = 1'b1;
      end else if (err_clr) begin
         verify_err_d = 1'b0;
      end
   end

   // Bus and handshake outputs are decoded from the next state so they are flops.
   always_comb begin
      cs_d        = (state_d == S_WRITE) || (state_d == S_VERIFY);
      write_n_d   = (state_d != S_WRITE);
      writedata_d = (state_d == S_WRITE) ? hold_d : writedata_q;
      ack0_d      = (state_d == S_DONE) && !gnt_d;
      ack1_d      = (state_d == S_DONE) && gnt_d;
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         cs_q         <= 1'b0;
         write_n_q    <= 1'b1;
         writedata_q  <= '0;
         busy_q       <= 1'b0;
         verify_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         cs_q         <= cs_d;
         write_n_q    <= write_n_d;
         writedata_q  <= writedata_d;
         busy_q       <= busy_d;
         verify_err_q <= verify_err_d;
      end
   end

   assign m_address    = 2'b00;
   assign m_chipselect = cs_q;
   assign m_write_n    = write_n_q;
   assign m_writedata  = writedata_q;
   assign ack0         = ack0_q;
   assign ack1         = ack1_q;
   assign busy         = busy_q;
   assign verify_err   = verify_err_q;
   assign last_grant   = last_grant_q;

endmodule
`default_nettype wire
